// File: rtl/registrador_universal.sv
// Universal shift register: hold, parallel load, shift right/left, synchronous preset,
// wrap counter with DONE pulse. Define REG_ROTATE_EN to make shifts rotate instead of using SIN.
module registrador_universal #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           CLR,
    input  logic                           PR,
    input  logic [1:0]                     MODE,
    input  logic [WIDTH-1:0]               D,
    input  logic                           SIN,
    output logic [WIDTH-1:0]               Q,
    output logic                           SOUT,
    output logic                           DONE,
    output logic [$clog2(WIDTH+1)-1:0]     CNT
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LEFT  = 2'b11;

    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic             sout_next;
    logic             done_next;
    logic             in_right;
    logic             in_left;

`ifdef REG_ROTATE_EN
    // The bit leaving one end re-enters at the other; SIN plays no part.
    logic unused_sin;
    assign unused_sin = SIN;
    assign in_right   = Q[0];
    assign in_left    = Q[WIDTH-1];
`else
    assign in_right   = SIN;
    assign in_left    = SIN;
`endif

    // Next-state selection: PR wins over MODE, every shift advances the wrap counter.
    always_comb begin
        q_next    = Q;
        cnt_next  = CNT;
        sout_next = SOUT;
        done_next = 1'b0;
        if (PR) begin
            q_next    = '1;
            cnt_next  = '0;
            sout_next = 1'b0;
        end else begin
            case (MODE)
                MODE_HOLD: begin
                end
                MODE_LOAD: begin
                    q_next    = D;
                    cnt_next  = '0;
                    sout_next = 1'b0;
                end
                MODE_RIGHT: begin
                    q_next    = {in_right, Q[WIDTH-1:1]};
                    sout_next = Q[0];
                end
                MODE_LEFT: begin
                    q_next    = {Q[WIDTH-2:0], in_left};
                    sout_next = Q[WIDTH-1];
                end
                default: begin
                end
            endcase
            if (MODE == MODE_RIGHT || MODE == MODE_LEFT) begin
                if (CNT == CW'(WIDTH - 1)) begin
                    cnt_next  = '0;
                    done_next = 1'b1;
                end else begin
                    cnt_next  = CNT + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            Q    <= RESET_VALUE;
            CNT  <= '0;
            SOUT <= 1'b0;
            DONE <= 1'b0;
        end else begin
            Q    <= q_next;
            CNT  <= cnt_next;
            SOUT <= sout_next;
            DONE <= done_next;
        end
    end

endmodule

// File: tb/tb_registrador_universal.sv
// Scoreboard bench for registrador_universal: driver pushes model expectations,
// a monitor pops and compares after every rising edge.
module tb_registrador_universal;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          clk_en = 1'b1;
    logic          CLR = 1'b1;
    logic          PR = 1'b0;
    logic [1:0]    MODE = 2'b00;
    logic [W-1:0]  D = '0;
    logic          SIN = 1'b0;
    logic [W-1:0]  Q;
    logic          SOUT;
    logic          DONE;
    logic [CW-1:0] CNT;

    typedef struct {
        int unsigned q;
        int unsigned sout;
        int unsigned cnt;
        int unsigned done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model state
    int unsigned mq    = 0;
    int unsigned mcnt  = 0;
    int unsigned msout = 0;
    int unsigned mdone = 0;

    registrador_universal #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
        .clk (clk),
        .CLR (CLR),
        .PR  (PR),
        .MODE(MODE),
        .D   (D),
        .SIN (SIN),
        .Q   (Q),
        .SOUT(SOUT),
        .DONE(DONE),
        .CNT (CNT)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic cmp(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mq = 0; mcnt = 0; msout = 0; mdone = 0;
    endtask

    // Advance the model by one shift of the wrap counter.
    task automatic model_count();
        mcnt = mcnt + 1;
        if (mcnt == W) begin
            mcnt  = 0;
            mdone = 1;
        end else begin
            mdone = 0;
        end
    endtask

    // Called with clk low, before a rising edge; returns at the following falling edge.
    task automatic step(input bit pr, input bit [1:0] mode, input int unsigned d, input bit sin);
        int unsigned bit_in;
        exp_t e;
        PR = pr; MODE = mode; D = W'(d); SIN = sin;
        if (pr) begin
            mq = MASK; mcnt = 0; msout = 0; mdone = 0;
        end else begin
            case (mode)
                2'd0: mdone = 0;
                2'd1: begin mq = d & MASK; mcnt = 0; msout = 0; mdone = 0; end
                2'd2: begin
                    msout = mq % 2;
`ifdef REG_ROTATE_EN
                    bit_in = mq % 2;
`else
                    bit_in = sin;
`endif
                    mq = (mq / 2) + bit_in * (1 << (W - 1));
                    model_count();
                end
                default: begin
                    msout = (mq >> (W - 1)) % 2;
`ifdef REG_ROTATE_EN
                    bit_in = msout;
`else
                    bit_in = sin;
`endif
                    mq = ((mq * 2) + bit_in) & MASK;
                    model_count();
                end
            endcase
        end
        e.q = mq; e.sout = msout; e.cnt = mcnt; e.done = mdone;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Stop the clock, pulse CLR between edges and check its effect right away.
    task automatic do_clr();
        clk_en = 1'b0;
        MODE   = 2'($urandom_range(3));
        #2 CLR = 1'b1;
        #1;
        cmp("clr_q", Q, 0);
        cmp("clr_cnt", CNT, 0);
        cmp("clr_done", DONE, 0);
        cmp("clr_sout", SOUT, 0);
        #1 CLR = 1'b0;
        model_reset();
        #10 clk_en = 1'b1;
    endtask

    // Monitor: every rising edge presents a new register state to score.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            cmp("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            cmp("sb_q", Q, e.q);
            cmp("sb_sout", SOUT, e.sout);
            cmp("sb_cnt", CNT, e.cnt);
            cmp("sb_done", DONE, e.done);
        end
    end

    initial begin
        logic [7:0] seq;
        #1;
        cmp("rst_q", Q, 0);
        cmp("rst_cnt", CNT, 0);
        cmp("rst_done", DONE, 0);
        #1 CLR = 1'b0;

        // Load A5h, eight right shifts with SIN=0: SOUT emits A5h LSB first.
        seq = 8'hA5;
        step(0, 2'd1, 'hA5, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 2'd2, 0, 0);
            cmp("a5_sout", SOUT, seq[i]);
            cmp("a5_done", DONE, (i == 7) ? 1 : 0);
        end
        cmp("a5_q", Q, 0);
        cmp("a5_cnt", CNT, 0);
        step(0, 2'd0, 0, 0);
        cmp("a5_done_clear", DONE, 0);

        // Load 81h, left shift with SIN=1.
        step(0, 2'd1, 'h81, 0);
        step(0, 2'd3, 0, 1);
`ifdef REG_ROTATE_EN
        cmp("l81_q", Q, 'h03);
`else
        cmp("l81_q", Q, 'h03);
`endif
        cmp("l81_sout", SOUT, 1);
        cmp("l81_cnt", CNT, 1);

        // Load 3Ch, seven shifts, then PR on the would-be wrap.
        step(0, 2'd1, 'h3C, 0);
        for (int i = 0; i < 7; i++) step(0, 2'(2 + (i % 2)), 0, 1);
        cmp("pre_pr_cnt", CNT, 7);
        step(1, 2'd2, 0, 1);
        cmp("pr_q", Q, 'hFF);
        cmp("pr_cnt", CNT, 0);
        cmp("pr_done", DONE, 0);

        // Five shifts, three holds, three shifts: DONE on the eighth shift.
        for (int i = 0; i < 5; i++) step(0, 2'd3, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 1);
        cmp("gap_cnt", CNT, 5);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'd2, 0, 1);
            cmp("gap_done", DONE, (i == 2) ? 1 : 0);
        end
        cmp("gap_cnt_after", CNT, 0);

        // Mid-sequence clear discards the partial count.
        for (int i = 0; i < 3; i++) step(0, 2'd2, 0, 1);
        do_clr();
        step(0, 2'd3, 0, 1);
        cmp("post_clr_cnt", CNT, 1);

`ifdef REG_ROTATE_EN
        step(0, 2'd1, 'h81, 0);
        step(0, 2'd2, 0, 0);
        cmp("rot_q1", Q, 'hC0);
        cmp("rot_sout1", SOUT, 1);
        for (int i = 0; i < 7; i++) step(0, 2'd2, 0, 0);
        cmp("rot_q8", Q, 'h81);
        cmp("rot_done", DONE, 1);
`endif

        // Randomized traffic with occasional preset and asynchronous clear.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) do_clr();
            step(($urandom_range(15) == 0), 2'($urandom_range(3)), $urandom, 1'($urandom));
        end

        cmp("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/registrador_universal.md
REGISTRADOR_UNIVERSAL -- requirements
Module: registrador_universal

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0: WIDTH-bit value that Q takes on reset.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port CLR, input, 1: asynchronous, active-high reset.
REQ-005 Port PR, input, 1: synchronous preset; Q set to all ones.
REQ-006 Port MODE, input, 2: operation select; 00 hold, 01 parallel load, 10 shift right, 11 shift left.
REQ-007 Port D, input, WIDTH: parallel load data.
REQ-008 Port SIN, input, 1: serial input bit for shift operations.
REQ-009 Port Q, output, WIDTH: register contents.
REQ-010 Port SOUT, output, 1: bit shifted out in the most recent shift cycle, registered.
REQ-011 Port DONE, output, 1: one-cycle pulse when WIDTH consecutive-count shifts have completed.
REQ-012 Port CNT, output, clog2(WIDTH+1): number of shifts since the last load, preset or reset.

Function
REQ-013 Priority per edge: PR > MODE; CLR overrides everything asynchronously.
REQ-014 PR=1: Q <= all ones; CNT <= 0; SOUT <= 0; DONE <= 0.
REQ-015 MODE=00: Q, CNT and SOUT hold; DONE <= 0.
REQ-016 MODE=01: Q <= D; CNT <= 0; SOUT <= 0; DONE <= 0; latency 1 cycle.
REQ-017 MODE=10: Q <= {SIN, Q[WIDTH-1:1]}; SOUT <= Q[0].
REQ-018 MODE=11: Q <= {Q[WIDTH-2:0], SIN}; SOUT <= Q[WIDTH-1].
REQ-019 Each shift cycle: when CNT = WIDTH-1, CNT <= 0 and DONE <= 1; otherwise CNT <= CNT+1 and DONE <= 0.
REQ-020 Direction changes between shifts do not reset CNT; mixed left and right shifts count together.
REQ-021 Hold cycles between shifts keep CNT, so DONE fires on the WIDTH-th shift cycle regardless of gaps.
REQ-022 DONE is high for exactly one cycle per wrap and never stays high across two edges unless a further wrap occurs.
REQ-023 PR or a load asserted in the same cycle as a would-be wrap suppresses DONE and sets CNT to 0.
REQ-024 Outputs are registered only; no combinational path from inputs to outputs.

Reset
REQ-025 CLR=1 immediately sets Q=RESET_VALUE, CNT=0, SOUT=0, DONE=0, with no dependence on clk.
REQ-026 CLR asserted mid-shift-sequence discards the partial count; the first shift after release counts as 1.
REQ-027 On the first edge after CLR deasserts, normal operation applies to that edge's inputs.

Configuration
REQ-028 With macro REG_ROTATE_EN defined, MODE=10 and MODE=11 rotate: Q[0] (right) or Q[WIDTH-1] (left) re-enters in place of SIN; SIN is ignored; SOUT and CNT behave as in REQ-017 to REQ-019.
REQ-029 With REG_ROTATE_EN undefined, shifts use SIN exactly as in REQ-017 and REQ-018, and no rotate logic exists.

Verification
REQ-030 WIDTH=8, CLR pulse mid-cycle with clk stopped -> Q=00h, CNT=0, DONE=0 immediately.
REQ-031 Load D=A5h, then 8 right shifts with SIN=0 -> SOUT sequence 1,0,1,0,0,1,0,1; Q=00h; DONE high only after the 8th shift; CNT=0.
REQ-032 Load 81h, left shift with SIN=1 -> Q=03h, SOUT=1, CNT=1.
REQ-033 Load 3Ch, 7 shifts, then PR together with MODE=10 -> Q=FFh, CNT=0, no DONE.
REQ-034 5 shifts, 3 hold cycles, 3 shifts -> DONE pulses on the 8th shift; CNT=0 after the pulse.
REQ-035 REG_ROTATE_EN defined: load 81h, one right shift -> Q=C0h, SOUT=1; 8 right shifts from the load -> Q=81h and DONE pulses once.
